// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - programmable I2C SCL generator with phase ticks and clock stretching
module i2c_scl_gen #(
  parameter int CNT_W   = 16,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             stretch_en,
  input  logic             scl_in,
  output logic             scl_out,
  output logic             scl_oe,
  output logic             tick_fall,
  output logic             tick_low_mid,
  output logic             tick_rise,
  output logic             tick_high_mid,
  output logic             stretching,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B} state_t;

  localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             scl_q, scl_d;
  logic             tf_q, tf_d, tlm_q, tlm_d, tr_q, tr_d, thm_q, thm_d;
  logic             str_q, str_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] div_clamped;
  logic             hold;

  assign div_clamped = (div < MIN_DIV_V) ? MIN_DIV_V : div;
  // A slave holding SCL low freezes the high quarter, including when cnt is already 0.
  assign hold        = (state_q == HIGH_A) && stretch_en && !sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    scl_d   = scl_q;
    tf_d    = 1'b0;
    tlm_d   = 1'b0;
    tr_d    = 1'b0;
    thm_d   = 1'b0;
    str_d   = 1'b0;
    case (state_q)
      IDLE: begin
        scl_d = 1'b1;
        if (en) begin
          div_d   = div_clamped;
          cnt_d   = div_clamped;
          state_d = LOW_A;
          scl_d   = 1'b0;
          tf_d    = 1'b1;
        end
      end
      LOW_A: begin
        if (cnt_q == '0) begin
          state_d = LOW_B;
          cnt_d   = div_q;
          tlm_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOW_B: begin
        if (cnt_q == '0) begin
          state_d = HIGH_A;
          cnt_d   = div_q;
          scl_d   = 1'b1;
          tr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HIGH_A: begin
        if (hold) begin
          str_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = HIGH_B;
          cnt_d   = div_q;
          thm_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HIGH_B: begin
        if (cnt_q == '0) begin
          if (en) begin
            div_d   = div_clamped;
            cnt_d   = div_clamped;
            state_d = LOW_A;
            scl_d   = 1'b0;
            tf_d    = 1'b1;
          end else begin
            state_d = IDLE;
            scl_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        scl_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= MIN_DIV_V;
      scl_q   <= 1'b1;
      tf_q    <= 1'b0;
      tlm_q   <= 1'b0;
      tr_q    <= 1'b0;
      thm_q   <= 1'b0;
      str_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      scl_q   <= scl_d;
      tf_q    <= tf_d;
      tlm_q   <= tlm_d;
      tr_q    <= tr_d;
      thm_q   <= thm_d;
      str_q   <= str_d;
      sync1_q <= scl_in;
      sync2_q <= sync1_q;
    end
  end

  assign scl_out       = scl_q;
  assign scl_oe        = ~scl_q;
  assign tick_fall     = tf_q;
  assign tick_low_mid  = tlm_q;
  assign tick_rise     = tr_q;
  assign tick_high_mid = thm_q;
  assign stretching    = str_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - directed self-checking bench for i2c_scl_gen
module tb_i2c_scl_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = 16'd3;
  logic        stretch_en = 1'b0;
  logic        scl_in = 1'b1;
  logic        scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid;
  logic        stretching, busy;

  int checks = 0;
  int failures = 0;
  int onehot_viol = 0;
  int oe_viol = 0;

  // per-cycle capture, index = cycle number after the start edge
  bit tf_a[0:127], tlm_a[0:127], tr_a[0:127], thm_a[0:127];
  bit so_a[0:127], st_a[0:127], bz_a[0:127];

  i2c_scl_gen #(.CNT_W(16), .MIN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .stretch_en(stretch_en),
    .scl_in(scl_in), .scl_out(scl_out), .scl_oe(scl_oe), .tick_fall(tick_fall),
    .tick_low_mid(tick_low_mid), .tick_rise(tick_rise), .tick_high_mid(tick_high_mid),
    .stretching(stretching), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input int which, input int start, input int last);
    for (int c = start; c <= last; c++) begin
      case (which)
        0: if (tf_a[c]) return c;
        1: if (tlm_a[c]) return c;
        2: if (tr_a[c]) return c;
        default: if (thm_a[c]) return c;
      endcase
    end
    return -1;
  endfunction

  function automatic int count_bits(input int which, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) begin
      if (which == 0 && so_a[c]) n++;
      if (which == 1 && st_a[c]) n++;
    end
    return n;
  endfunction

  // Starts a run from idle (caller is at a negedge), captures n cycles, then drains to idle.
  task automatic run(input int d, input bit se, input int n, input int drop_at,
                     input int chg_at, input int new_d, input int f0, input int f1);
    int guard;
    div = 16'(d);
    stretch_en = se;
    scl_in = 1'b1;
    en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tf_a[c] = tick_fall; tlm_a[c] = tick_low_mid; tr_a[c] = tick_rise; thm_a[c] = tick_high_mid;
      so_a[c] = scl_out; st_a[c] = stretching; bz_a[c] = busy;
      if ((32'(tick_fall) + 32'(tick_low_mid) + 32'(tick_rise) + 32'(tick_high_mid)) > 1) onehot_viol++;
      if (scl_oe !== ~scl_out) oe_viol++;
      if (c == drop_at) en = 1'b0;
      if (c == chg_at) div = 16'(new_d);
      scl_in = (c >= f0 && c <= f1) ? 1'b0 : scl_out;
    end
    en = 1'b0;
    stretch_en = 1'b0;
    scl_in = 1'b1;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy) begin
      $display("FAIL drain_idle: busy=%0b after %0d cycles, required 0", busy, guard);
      failures++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, stretching, busy} !== 8'b1000_0000) begin
      $display("FAIL reset_outputs: got %b required 10000000",
               {scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, stretching, busy});
      failures++;
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    int got[5];
    int exp_c[5] = '{1, 5, 9, 13, 17};
    run(3, 1'b0, 40, -1, -1, 0, -1, -1);
    got[0] = first_from(0, 1, 40); got[1] = first_from(1, 1, 40); got[2] = first_from(2, 1, 40);
    got[3] = first_from(3, 1, 40); got[4] = first_from(0, 2, 40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin
        $display("FAIL basic_tick%0d: cycle %0d, required %0d", i, got[i], exp_c[i]);
        failures++;
      end
    end
    for (int c = 1; c <= 16; c++) if (so_a[c] !== (c >= 9)) bad++;
    checks++;
    if (bad !== 0) begin
      $display("FAIL basic_scl_shape: %0d wrong cycles, required 0", bad);
      failures++;
    end
  endtask

  task automatic test_clamp();
    int got[5];
    int exp_c[5] = '{1, 4, 7, 10, 13};
    run(0, 1'b0, 30, -1, -1, 0, -1, -1);
    got[0] = first_from(0, 1, 30); got[1] = first_from(1, 1, 30); got[2] = first_from(2, 1, 30);
    got[3] = first_from(3, 1, 30); got[4] = first_from(0, 2, 30);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin
        $display("FAIL clamp_tick%0d: cycle %0d, required %0d", i, got[i], exp_c[i]);
        failures++;
      end
    end
    checks++;
    if (count_bits(0, 1, 12) !== 6) begin
      $display("FAIL clamp_high_cycles: %0d, required 6", count_bits(0, 1, 12));
      failures++;
    end
  endtask

  task automatic test_stretch();
    int got[5];
    int exp_c[5] = '{15, 19, 27, 53, 57};
    run(3, 1'b1, 60, -1, -1, 0, 27, 46);
    got[0] = first_from(3, 1, 60); got[1] = first_from(0, 2, 60); got[2] = first_from(2, 20, 60);
    got[3] = first_from(3, 20, 60); got[4] = first_from(0, 20, 60);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp_c[i]) begin
        $display("FAIL stretch_tick%0d: cycle %0d, required %0d", i, got[i], exp_c[i]);
        failures++;
      end
    end
    checks++;
    if (count_bits(1, 1, 18) !== 2) begin
      $display("FAIL stretch_sync_latency: %0d stretching cycles, required 2", count_bits(1, 1, 18));
      failures++;
    end
    checks++;
    if (count_bits(1, 19, 56) !== 22) begin
      $display("FAIL stretch_held: %0d stretching cycles, required 22", count_bits(1, 19, 56));
      failures++;
    end
  endtask

  task automatic test_en_drop();
    run(3, 1'b0, 30, 6, -1, 0, -1, -1);
    checks++;
    if (first_from(3, 1, 30) !== 13) begin
      $display("FAIL drop_high_mid: cycle %0d, required 13", first_from(3, 1, 30));
      failures++;
    end
    checks++;
    if ({bz_a[16], bz_a[17]} !== 2'b10) begin
      $display("FAIL drop_busy_fall: busy16/17=%b, required 10", {bz_a[16], bz_a[17]});
      failures++;
    end
    checks++;
    if (first_from(0, 2, 30) !== -1) begin
      $display("FAIL drop_no_fall: tick_fall at %0d, required none (-1)", first_from(0, 2, 30));
      failures++;
    end
    checks++;
    if (count_bits(0, 9, 30) !== 22) begin
      $display("FAIL drop_scl_high: %0d high cycles, required 22", count_bits(0, 9, 30));
      failures++;
    end
  endtask

  task automatic test_div_change();
    run(3, 1'b0, 60, -1, 10, 7, -1, -1);
    checks++;
    if (first_from(0, 2, 60) !== 17) begin
      $display("FAIL divchg_cur_period: fall at %0d, required 17", first_from(0, 2, 60));
      failures++;
    end
    checks++;
    if (first_from(2, 18, 60) !== 33) begin
      $display("FAIL divchg_next_rise: rise at %0d, required 33", first_from(2, 18, 60));
      failures++;
    end
    checks++;
    if (first_from(0, 18, 60) !== 49) begin
      $display("FAIL divchg_next_period: fall at %0d, required 49", first_from(0, 18, 60));
      failures++;
    end
  endtask

  task automatic test_reset_midop();
    div = 16'd3;
    en = 1'b1;
    @(posedge clk);
    repeat (14) @(negedge clk);
    checks++;
    if ({scl_out, busy} !== 2'b11) begin
      $display("FAIL rst_pre_highb: scl_out/busy=%b, required 11", {scl_out, busy});
      failures++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, busy} !== 7'b1000000) begin
      $display("FAIL rst_in_highb: got %b required 1000000",
               {scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, busy});
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({scl_out, busy} !== 2'b01) begin
      $display("FAIL rst_pre_lowa: scl_out/busy=%b, required 01", {scl_out, busy});
      failures++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, busy} !== 7'b1000000) begin
      $display("FAIL rst_in_lowa: got %b required 1000000",
               {scl_out, scl_oe, tick_fall, tick_low_mid, tick_rise, tick_high_mid, busy});
      failures++;
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(3, 1'b0, 20, -1, -1, 0, -1, -1);
    checks++;
    if ({first_from(0, 1, 20), first_from(2, 1, 20), first_from(0, 2, 20)} !== {32'sd1, 32'sd9, 32'sd17}) begin
      $display("FAIL rst_restart: fall/rise/fall=%0d/%0d/%0d, required 1/9/17",
               first_from(0, 1, 20), first_from(2, 1, 20), first_from(0, 2, 20));
      failures++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clamp();
    test_stretch();
    test_en_drop();
    test_div_change();
    test_reset_midop();
    checks++;
    if (onehot_viol !== 0) begin
      $display("FAIL tick_onehot: %0d cycles with multiple ticks, required 0", onehot_viol);
      failures++;
    end
    checks++;
    if (oe_viol !== 0) begin
      $display("FAIL scl_oe_inverse: %0d cycles scl_oe != ~scl_out, required 0", oe_viol);
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
- Programmable SCL generator for the I2C master. Replaces the fixed divide-by-2 SCL source.
- Produces an SCL waveform whose quarter-period length is set at run time.
- Emits four single-cycle phase ticks that the master FSM uses to change SDA (low_mid) and sample SDA (high_mid).
- Supports slave clock stretching through a synchronised readback of the SCL bus line.

Parameters:
- CNT_W, 16: width of the quarter-period divider and counter.
- MIN_DIV, 2: smallest effective divider. Any div below it is clamped to MIN_DIV.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- div  in  CNT_W  quarter period minus 1, in clk cycles.
- stretch_en  in  1  1 = honour slave clock stretching.
- scl_in  in  1  raw SCL bus level (asynchronous).
- scl_out  out  1  SCL level driven (1 = released).
- scl_oe  out  1  open-drain enable; equals ~scl_out.
- tick_fall  out  1  1-cycle pulse in the first cycle of SCL low.
- tick_low_mid  out  1  1-cycle pulse at the middle of SCL low (SDA change point).
- tick_rise  out  1  1-cycle pulse in the first cycle of SCL high.
- tick_high_mid  out  1  1-cycle pulse at the middle of SCL high (SDA sample point).
- stretching  out  1  high while a slave holds SCL low.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE, cnt = 0, div_q = MIN_DIV.
  - scl_out = 1, scl_oe = 0.
  - All ticks = 0, stretching = 0, busy = 0.
  - Both scl_in synchroniser flops = 1.
- Reset asserted mid-operation forces scl_out = 1 immediately (asynchronous), with no completion of the current period.
- All outputs are registered. scl_oe and busy are decoded from registered state only.
- scl_in passes through a 2-flop synchroniser to give scl_sync.
- States: IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B.
- IDLE:
  - scl_out = 1.
  - When en = 1 at a posedge: latch div_q = max(div, MIN_DIV), set cnt = div_q, go to LOW_A with scl_out = 0 and tick_fall = 1.
- Counting: in each quarter state cnt decrements by 1 per cycle. The state advances on the cycle after cnt == 0, so each unstretched quarter lasts div_q+1 cycles.
- LOW_A -> LOW_B: reload cnt, tick_low_mid = 1.
- LOW_B -> HIGH_A: scl_out = 1, reload cnt, tick_rise = 1.
- HIGH_A (clock stretching):
  - If stretch_en = 1 and scl_sync = 0, cnt holds its value and stretching = 1. Otherwise cnt decrements.
  - On exit: HIGH_A -> HIGH_B, reload cnt, tick_high_mid = 1.
- HIGH_B:
  - If en = 1: go to LOW_A, re-latch div_q from div, scl_out = 0, tick_fall = 1.
  - If en = 0: go to IDLE with scl_out = 1 and no tick.
- Period and timing:
  - With stretch_en = 0, period = 4*(div_q+1) cycles at a 50% duty cycle.
  - With stretch_en = 1 on an unstretched bus, HIGH_A gains 2 cycles of synchroniser latency, so period = 4*(div_q+1)+2.
- div changes take effect only at the next LOW_A entry.
- Deasserting en never truncates a period: the block finishes HIGH_B, then goes idle.
- stretch_en changes apply immediately, including within HIGH_A.
- scl_in is ignored outside HIGH_A.
- At most one tick is high in any cycle.
- cnt never wraps, because it is always reloaded at 0.

Test Plan:
- stretch_en = 0, div = 3, en = 1 at edge 0 →
  - tick_fall at cycles 1 and 17; tick_low_mid at 5; tick_rise at 9; tick_high_mid at 13.
  - scl_out low for cycles 1–8 and high for 9–16; period 16.
- div = 0 (clamped to MIN_DIV = 2), stretch_en = 0 → period 12; scl_out low 6 cycles, high 6 cycles.
- stretch_en = 1, div = 3, scl_in driven = scl_out (bus model) → period 18.
  - Then hold scl_in low for 20 cycles after tick_rise → stretching high about 20 cycles, tick_high_mid delayed by the same amount, cnt frozen during the stretch.
- en dropped during LOW_B → the period completes, busy falls after HIGH_B, scl_out stays 1, and no further tick_fall occurs.
- div changed from 3 to 7 during HIGH_A → the current period stays 16 cycles; the next period is 32.
- rst_n pulsed low during HIGH_B while scl_out = 1, then during LOW_A while scl_out = 0 → scl_out = 1, ticks = 0 and busy = 0 asynchronously; a restart with en = 1 gives a normal first period.
